program_counter: RTL
====================

# program_counter

Parametrised instruction-address sequencer for the venera CPU fetch path. It generates a one-cycle read strobe once per instruction period of `PHASES` clocks and advances the fetch address after each strobe. It accepts jumps, subroutine calls and returns, and can be stalled with a hold input. An optional hardware return-address stack supports call/return.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: fetch address width; the address wraps modulo 2^ADDR_WIDTH.
- `PHASES`, 4: clocks per instruction period; legal values 2..16.
- `STACK_DEPTH`, 4: number of return-stack entries; legal values 1..16.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `hold`  in  1: stall; freezes the phase and the address, and forces `rd` low.
- `set_valid`  in  1: jump request, target on `set_value`.
- `call_valid`  in  1: call request, target on `set_value`.
- `ret_valid`  in  1: return request.
- `set_value`  in  ADDR_WIDTH: jump/call target.
- `rd`  out  1: fetch strobe.
- `address`  out  ADDR_WIDTH: current fetch address.
- `phase`  out  $clog2(PHASES): current phase index.
- `depth`  out  $clog2(STACK_DEPTH+1): number of occupied stack entries.
- `stack_err`  out  1: sticky overflow/underflow flag.

## Operation
- Reset state: `phase`=0, `address`=0, `depth`=0, `stack_err`=0, `rd`=0. Stack contents are don't-care.
- Phase counter:
  - Counts 0..PHASES-1 and wraps to 0.
  - Advances every cycle with `hold`=0.
- `rd` = (`phase`==PHASES-1) && !`hold`. It is decoded from registered state, with no extra latency.
- Per-cycle priority, one action only: `reset` > `ret_valid` > `call_valid` > `set_valid` > increment.
- Increment: at the end of a cycle with `rd`=1, `address` <= `address`+1. This wraps from 2^ADDR_WIDTH-1 to 0.
- Jump (`set_valid`): `address` <= `set_value`, `phase` <= 0.
- Call (`call_valid`):
  - Push `address`+1 (wrapped) and increment `depth`.
  - Then `address` <= `set_value`, `phase` <= 0.
- Return (`ret_valid`): `address` <= top entry, decrement `depth`, `phase` <= 0.
- Control actions (jump/call/return) take effect even when `hold`=1. No increment occurs in a cycle where a control action is taken, even if `rd`=1 that cycle.
- Overflow: a call with `depth`==STACK_DEPTH drops the push, leaves `depth` unchanged, still loads `set_value`, and sets `stack_err`.
- Underflow: a return with `depth`==0 leaves `address` unchanged, sets `phase` <= 0, and sets `stack_err`.
- `stack_err` clears only on `reset`.
- Reset mid-operation: abandons the instruction period and any stack contents. `rd` is low in the cycle after reset is asserted.

## Timing
- After `reset` deasserts (cycle 0, `phase`=0), `rd` pulses in cycles PHASES-1, 2·PHASES-1, and so on. With `PHASES`=4 this matches the legacy 4-tact fetch rhythm.
- `address` changes in the cycle after an `rd` pulse.
- Jump/call/return: the new `address` is visible the next cycle. The first `rd` at the new address follows PHASES cycles after the request cycle.
- `hold`: the cycle after `hold` deasserts resumes at the frozen `phase`. An `rd` suppressed by hold is re-issued when hold drops.
- `depth` and `stack_err` update one cycle after the request.

## Configuration
- Macro `PC_CALL_STACK_EN`.
- Defined: the return stack, `call_valid` and `ret_valid` behave as above.
- Undefined:
  - No stack storage is built.
  - `call_valid` behaves exactly as `set_valid`.
  - `ret_valid` is ignored.
  - `depth` is tied to 0 and `stack_err` is tied to 0.

## Test plan
- Reset, then run 12 cycles (PHASES=4) -> `rd` high in cycles 3, 7, 11 only; `address` goes 0 -> 1 at cycle 4 and 1 -> 2 at cycle 8.
- Jump to 8'h40 at cycle 2 -> `address`=8'h40 at cycle 3, `phase`=0; next `rd` at cycle 6; then `address`=8'h41.
- Call 8'h80 from `address`=8'h05 -> `depth`=1, `address`=8'h80. A later return -> `address`=8'h06, `depth`=0, `stack_err`=0.
- Boundary stack cases (STACK_DEPTH=4):
  - Five calls -> `depth` stays 4, `stack_err`=1; the fifth target is still loaded.
  - Return at `depth`=0 -> `address` unchanged, `stack_err`=1.
- Wrap and simultaneous requests:
  - `address`=8'hFF with `rd` -> `address`=8'h00.
  - Call with return address 8'hFF+1 pushes 8'h00.
  - `set_valid` and `ret_valid` in the same cycle -> return wins.
- Hold and reset:
  - `hold` held across `phase`=3 for 5 cycles -> `rd` low and `address` frozen; `rd` pulses on the first cycle after `hold` drops.
  - `reset` asserted mid-period -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/program_counter.sv
// Instruction-address sequencer: one rd strobe per PHASES-clock period, jumps, calls, returns, hold.
// Define PC_CALL_STACK_EN to build the hardware return-address stack; otherwise call acts as jump.
module program_counter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PHASES      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             hold,
  input  logic                             set_valid,
  input  logic                             call_valid,
  input  logic                             ret_valid,
  input  logic [ADDR_WIDTH-1:0]            set_value,
  output logic                             rd,
  output logic [ADDR_WIDTH-1:0]            address,
  output logic [$clog2(PHASES)-1:0]        phase,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_err
);
  localparam int PW = $clog2(PHASES);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [PW-1:0]         phase_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  last;

  assign last = (phase == PW'(PHASES - 1));
  assign rd   = last && !hold;

`ifdef PC_CALL_STACK_EN
  // Entry count rounded up to a power of two so index width matches the array.
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] stack_mem [2**IW];
  logic [DW-1:0]         depth_q, depth_nxt;
  logic                  err_q, err_nxt, push;
  logic [IW-1:0]         push_idx, top_idx;
  logic [ADDR_WIDTH-1:0] ret_addr;

  assign push_idx  = IW'(depth_q);
  assign top_idx   = IW'(depth_q - DW'(1));
  assign ret_addr  = address + ADDR_WIDTH'(1);
  assign depth     = depth_q;
  assign stack_err = err_q;

  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= ret_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      depth_q <= depth_nxt;
      err_q   <= err_nxt;
    end
  end
`else
  logic unused_ret;
  assign unused_ret = ret_valid;
  assign depth      = '0;
  assign stack_err  = 1'b0;
`endif

  always_comb begin
    phase_nxt = phase;
    addr_nxt  = address;
`ifdef PC_CALL_STACK_EN
    depth_nxt = depth_q;
    err_nxt   = err_q;
    push      = 1'b0;
    if (ret_valid) begin
      phase_nxt = '0;
      if (depth_q != '0) begin
        addr_nxt  = stack_mem[top_idx];
        depth_nxt = depth_q - DW'(1);
      end else begin
        err_nxt = 1'b1;
      end
    end else if (call_valid) begin
      phase_nxt = '0;
      addr_nxt  = set_value;
      // A full stack drops the push but the target is still taken.
      if (depth_q == DW'(STACK_DEPTH)) begin
        err_nxt = 1'b1;
      end else begin
        push      = 1'b1;
        depth_nxt = depth_q + DW'(1);
      end
    end else
`endif
    if (set_valid || call_valid) begin
      phase_nxt = '0;
      addr_nxt  = set_value;
    end else if (!hold) begin
      phase_nxt = last ? '0 : phase + PW'(1);
      if (rd) addr_nxt = address + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      address <= '0;
    end else begin
      phase   <= phase_nxt;
      address <= addr_nxt;
    end
  end
endmodule
